prog_loader: RTL and testbench

//  Byte-stream program loader: fills the 32-word instruction memory that the PC/COUNTER5B path reads.

---
 rtl/prog_loader.sv | 178 +++++++++++++++++
 tb/tb_prog_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: frames big-endian bytes into words, writes them to instruction
// memory and releases the CPU reset only after a checksummed image has loaded.
module prog_loader #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_write,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned MaxWords = 2 ** ADDR_W;
  localparam int unsigned TimerW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StWrite,
    StCsum,
    StDone,
    StErr
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [7:0]          csum_q, csum_d;
  logic [TimerW-1:0]   timer_q, timer_d;

  logic                byte_ready_q, byte_ready_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic                mem_write_q, mem_write_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                accept;
  logic [31:0]         len_ext;
  logic [ADDR_W:0]     last_idx;

  assign accept   = byte_valid & byte_ready_q;
  assign len_ext  = {24'd0, byte_data};
  assign last_idx = len_q - (ADDR_W + 1)'(1);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    csum_d     = csum_q;
    timer_d    = timer_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StLen;
          idx_d   = '0;
          cnt_d   = '0;
          timer_d = '0;
        end
      end
      StLen, StData, StCsum: begin
        // Timeout wins even if a byte arrives on the same edge.
        if (timer_q == TimerW'(TIMEOUT)) begin
          state_d = StErr;
        end else if (!accept) begin
          timer_d = timer_q + 1'b1;
        end else begin
          timer_d = '0;
          if (state_q == StLen) begin
            if (len_ext == 32'd0 || len_ext > MaxWords) begin
              state_d = StErr;
            end else begin
              len_d   = byte_data[ADDR_W:0];
              csum_d  = byte_data;
              state_d = StData;
            end
          end else if (state_q == StData) begin
            word_d = {word_q[DATA_W-9:0], byte_data};
            csum_d = csum_q ^ byte_data;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == 2'd3) begin
              state_d = StWrite;
            end
          end else begin
            state_d = (byte_data == csum_q) ? StDone : StErr;
          end
        end
      end
      StWrite: begin
        if ({1'b0, idx_q} == last_idx) begin
          state_d = StCsum;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StData;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    byte_ready_d = state_d inside {StLen, StData, StCsum};
    busy_d       = state_d inside {StLen, StData, StWrite, StCsum};
    done_d       = (state_d == StDone);
    error_d      = (state_d == StErr);
    cpu_rst_d    = (state_d != StDone);
    mem_write_d  = (state_d == StWrite);
    if (state_d == StWrite) begin
      mem_addr_d = idx_q;
      mem_data_d = word_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      len_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      timer_q      <= '0;
      byte_ready_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_write_q  <= 1'b0;
      cpu_rst_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      timer_q      <= timer_d;
      byte_ready_q <= byte_ready_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_write_q  <= mem_write_d;
      cpu_rst_q    <= cpu_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_write  = mem_write_q;
  assign cpu_rst    = cpu_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected writes and end-of-load status,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_prog_loader;

  localparam int unsigned TIMEOUT = 1023;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_write;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;

  prog_loader #(
    .ADDR_W (5),
    .DATA_W (32),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_write (mem_write),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [36:0] exp_wr[$];  // {addr, data}
  logic [2:0]  exp_st[$];  // {done, error, cpu_rst} once busy falls
  logic        busy_prev = 1'b0;

  // Monitor: every write strobe and every busy falling edge consumes one expectation.
  always @(negedge CLK) begin
    logic [36:0] ew;
    logic [2:0]  es;
    if (mem_write === 1'b1) begin
      n_cmp++;
      if (exp_wr.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write", mem_addr,
                 mem_data);
      end else begin
        ew = exp_wr.pop_front();
        if ({mem_addr, mem_data} !== ew) begin
          n_bad++;
          $display("FAIL mem_write: got addr %0d data %h, expected addr %0d data %h", mem_addr,
                   mem_data, ew[36:32], ew[31:0]);
        end
      end
    end
    if (busy_prev && busy === 1'b0) begin
      n_cmp++;
      if (exp_st.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_status: got done/error/cpu_rst %b, expected none",
                 {done, error, cpu_rst});
      end else begin
        es = exp_st.pop_front();
        if ({done, error, cpu_rst} !== es) begin
          n_bad++;
          $display("FAIL load_status: got done/error/cpu_rst %b, expected %b",
                   {done, error, cpu_rst}, es);
        end
      end
    end
    busy_prev = (busy === 1'b1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit sent = 1'b0;
    repeat (gap) tick();
    byte_data  = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (byte_ready === 1'b1) begin
        tick();
        sent = 1'b1;
        break;
      end
      tick();
    end
    byte_valid = 1'b0;
    if (!sent) begin
      n_cmp++;
      n_bad++;
      $display("FAIL byte_accept: byte %h not taken within 64 cycles, expected accept", b);
    end
  endtask

  task automatic wait_idle(input string name);
    bit idle = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (busy === 1'b0) begin
        idle = 1'b1;
        break;
      end
      tick();
    end
    if (!idle) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: busy still 1 after 64 cycles, expected 0", name);
    end
    repeat (2) tick();
  endtask

  // Image: N=01, DEADBEEF, checksum 01^DE^AD^BE^EF = 23.
  task automatic load_test1(input logic [7:0] csum);
    exp_wr.push_back({5'd0, 32'hDEADBEEF});
    exp_st.push_back((csum == 8'h23) ? 3'b100 : 3'b011);
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    send_byte(csum, 0);
    wait_idle("t1_idle");
  endtask

  initial begin
    logic [7:0] t2_bytes[12];
    int         cycles;

    t2_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    RST        = 1'b1;
    start      = 1'b0;
    byte_data  = 8'h00;
    byte_valid = 1'b0;
    #1;
    chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_flags", {30'd0, done, error}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    #20;
    RST = 1'b0;
    tick();

    // 1: single-word image with good checksum.
    load_test1(8'h23);
    chk("t1_cpu_rst", {31'd0, cpu_rst}, 32'd0);

    // 2: three words with gaps; checksum 03^11^22^...^CC = CF. A stray start mid-load is ignored.
    exp_wr.push_back({5'd0, 32'h11223344});
    exp_wr.push_back({5'd1, 32'h55667788});
    exp_wr.push_back({5'd2, 32'h99AABBCC});
    exp_st.push_back(3'b100);
    pulse_start();
    send_byte(8'h03, 1);
    for (int i = 0; i < 12; i++) begin
      if (i == 5) pulse_start();
      send_byte(t2_bytes[i], int'($urandom_range(0, 3)));
    end
    send_byte(8'hCF, 2);
    wait_idle("t2_idle");

    // 3: bad checksum; word still written, CPU stays in reset.
    load_test1(8'h24);
    chk("t3_cpu_rst", {31'd0, cpu_rst}, 32'd1);

    // 4: illegal lengths 0 and 33.
    exp_st.push_back(3'b011);
    pulse_start();
    send_byte(8'h00, 0);
    wait_idle("t4a_idle");
    exp_st.push_back(3'b011);
    pulse_start();
    send_byte(8'h21, 0);
    wait_idle("t4b_idle");

    // 5: stall after two data bytes; error after TIMEOUT+1 idle edges.
    exp_st.push_back(3'b011);
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    cycles = 0;
    while (error !== 1'b1 && cycles < 1200) begin
      tick();
      cycles++;
    end
    chk("t5_timeout_cycles", cycles, TIMEOUT + 1);
    chk("t5_byte_ready", {31'd0, byte_ready}, 32'd0);
    repeat (2) tick();

    // 6: async reset between edges in DATA, then a clean reload.
    exp_st.push_back(3'b001);
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    #2;
    RST = 1'b1;
    #1;
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("t6_rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    RST = 1'b0;
    repeat (2) tick();
    load_test1(8'h23);
    chk("t6_cpu_rst", {31'd0, cpu_rst}, 32'd0);

    repeat (3) tick();
    chk("left_writes", exp_wr.size(), 0);
    chk("left_status", exp_st.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1);
  end

endmodule
